sobel_edge_stream: RTL and testbench
====================================

# sobel_edge_stream

Parametrised streaming 3×3 Sobel edge detector. It succeeds the fixed 12-bit vertical/horizontal convolver and sits between the three-row line buffer and the display/output formatter. It accepts one vertical pixel triple per valid beat and produces one edge magnitude per beat. It adds:
- selectable Gx / Gy / |Gx|+|Gy| / max modes
- explicit row-border handling
- output saturation and scaling
- a 2-stage registered pipeline with column tagging

## Interface
- PIX_W, 12, input pixel width
- OUT_W, 12, output pixel width
- IMG_W, 640, pixels per row (≥ 3)
- OUT_SHIFT, 0, right shift applied before saturation
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  triple on row*_pixel accepted this cycle
- in_sol  in  1  start of line; qualifies with in_valid; current beat is column 0
- mode  in  2  0 = |Gx| (vertical edges), 1 = |Gy| (horizontal), 2 = |Gx|+|Gy|, 3 = max(|Gx|,|Gy|)
- row0_pixel, row1_pixel, row2_pixel  in  PIX_W  top/middle/bottom row pixel of the current column
- out_pix  out  OUT_W  edge value
- out_valid  out  1  out_pix/out_col/out_border valid
- out_col  out  $clog2(IMG_W)  column of the window centre
- out_border  out  1  centre is column 0 or IMG_W-1

## Operation
- No backpressure. Every beat with in_valid=1 is accepted. Gaps are allowed, and the pipeline advances every cycle carrying bubbles.
- Window: 3×3 register array. On accept, the new triple enters the right column and the existing columns shift left.
- Column counter col:
  - On accept with in_sol=1, col←1 (current beat is column 0).
  - Otherwise on accept, col←col+1, wrapping IMG_W-1→0.
  - The column index of the current beat is col's value before the update.
- Centre column for a beat at column c: c-1, or IMG_W-1 when c=0. out_border=1 for beats at c∈{0,1}.
- primed flag: cleared by reset, set on the first accept. The first accept after reset produces no output, because its centre is undefined.
- Column sums use weights (1,2,1) and are PIX_W+2 bits. Gx uses the right column minus the left column; Gy uses the bottom row minus the top row. Absolute values are PIX_W+2 bits.
- Mode 2 sum is PIX_W+3 bits. Mode 3 takes the larger absolute value.
- Output conversion: v = result >> OUT_SHIFT, then out_pix = (v > 2^OUT_W-1) ? 2^OUT_W-1 : v. No truncation wrap is allowed.
- mode is sampled together with each accepted triple and travels down the pipeline. A mode change takes effect exactly on the next accepted beat.
- Border handling without the macro: out_pix=0 whenever out_border=1.
- in_sol asserted while col≠0 re-aligns the counter; it is not an error. The current beat is treated as column 0 with border rules.

## Timing
- Stage 0: accept edge. Window, col, mode and primed are updated.
- Stage 1: the next edge registers |Gx|, |Gy|, mode, centre column, border flag and valid.
- Stage 2: the next edge registers out_pix, out_col, out_border and out_valid.
- Latency is 2 clocks from the accept edge to the out_valid=1 cycle. Throughput is 1 per clock.
- Reset (asynchronous, any time, mid-stream included) clears:
  - window=0, col=0, primed=0
  - out_pix=0, out_col=0, out_border=0, out_valid=0
  - all stage valids
- The first output is 2 clocks after the second accepted beat.
- The last centre of a frame (column IMG_W-1 of the final row) is emitted only when the next beat arrives. Upstream pads each frame with one beat.

## Configuration
- SOBEL_BORDER_REPLICATE_EN
- Defined: border beats replicate instead of zeroing.
  - Centre column IMG_W-1 uses the centre column as its right column.
  - Centre column 0 uses the centre column as its left column.
  - Gy is computed from the substituted window.
  - out_border is still asserted.
- Undefined: border outputs are forced to 0, and no replicate muxes are built.

## Structure
- sobel_pkg holds:
  - mode_e enum (MODE_GX, MODE_GY, MODE_SUM, MODE_MAX)
  - sum/abs width localparams derived from PIX_W
  - the saturation function
- One sub-module, sobel_window3x3. It holds the shift array, col counter, primed flag and border substitution, and outputs the effective 3×3 window and the centre-column tag.

## Test plan
Parameters for all scenarios: PIX_W=12, OUT_W=12, IMG_W=8, OUT_SHIFT=0.
1. Vertical step, all rows. Columns 0-3 = 0, columns 4-7 = 100, mode 0. Expect out_pix=400 for centre columns 3 and 4, and 0 for centre column 2 and centre columns 5-6.
2. Horizontal step. row0=0, row1=0, row2=1000 on all columns, mode 1. Expect interior output 4000; with mode 0, expect 0.
3. Saturation. row0=0, row2=4095, mode 2. Expect 4095 (raw value 16380). With OUT_SHIFT=2 and mode 1, expect 4095 (16380>>2=4095).
4. Border.
   - Without the macro: centre column 0 and centre column 7 give 0 with out_border=1.
   - With the macro and a uniform row of 50 plus a step at column 1 to 90: expect replicated-window results; out_col sequence 7,0,1,….
5. Gaps and mode switch. Insert 3-cycle in_valid gaps and change mode every beat. Expect out_valid exactly 2 clocks after each accept, each result using that beat's mode, and no duplicate or missing outputs.
6. Reset mid-stream. Assert rst with two beats in flight. Expect out_valid=0 immediately (asynchronous). After release, the first accept gives no output and the second accept's output appears 2 clocks later.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and helpers for the streaming Sobel edge detector.
//   mode_e       - output selection (|Gx|, |Gy|, |Gx|+|Gy|, max)
//   sum_width()  - width of a (1,2,1) weighted sum and of its absolute difference
//   tot_width()  - width of the |Gx|+|Gy| result
//   sat_u32()    - clamp a value to the largest OUT_W-bit unsigned number
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_GX  = 2'd0,
    MODE_GY  = 2'd1,
    MODE_SUM = 2'd2,
    MODE_MAX = 2'd3
  } mode_e;

  // A (1,2,1) sum of three PIX_W values needs two extra bits; adding the two
  // absolute gradients needs one more.
  localparam int SUM_EXTRA_W = 2;
  localparam int TOT_EXTRA_W = 3;

  function automatic int sum_width(input int pix_w);
    return pix_w + SUM_EXTRA_W;
  endfunction

  function automatic int tot_width(input int pix_w);
    return pix_w + TOT_EXTRA_W;
  endfunction

  // Saturating clamp; callers keep their value within 32 bits.
  function automatic logic [31:0] sat_u32(input logic [31:0] v, input int out_w);
    logic [31:0] max_v;
    if (out_w >= 32) max_v = '1;
    else             max_v = (32'd1 << out_w) - 32'd1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/sobel_window3x3.sv
// sobel_window3x3: 3x3 pixel window, column counter and border tagging.
// Each accepted vertical triple shifts in at the right (col 2) while the
// older columns move left. After an accept the window is centred on the
// previous beat, so the centre column is the current beat's column minus one.
// Optional feature macro: SOBEL_BORDER_REPLICATE_EN replaces the missing
// neighbour column at the row ends with the centre column.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid_i/in_sol_i triple accepted / beat is column 0
//   row0_i..row2_i      top/middle/bottom pixel of the incoming column
//   win_o[row][col]     effective window (col 0 = left, 2 = right)
//   win_valid_o         one-cycle pulse: win_o holds a complete window
//   cen_col_o           column of the window centre
//   border_o            centre is column 0 or IMG_W-1
module sobel_window3x3
  import sobel_pkg::*;
#(
  parameter  int PIX_W = 12,
  parameter  int IMG_W = 640,
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  input  logic                       in_sol_i,
  input  logic [PIX_W-1:0]           row0_i,
  input  logic [PIX_W-1:0]           row1_i,
  input  logic [PIX_W-1:0]           row2_i,
  output logic [2:0][2:0][PIX_W-1:0] win_o,
  output logic                       win_valid_o,
  output logic [CW-1:0]              cen_col_o,
  output logic                       border_o
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic [CW-1:0]              col_q, col_d, cur_col;
  logic [CW-1:0]              cen_q, cen_d;
  logic                       primed_q, primed_d;
  logic                       valid_q, valid_d;
  logic                       border_q, border_d;

  always_comb begin
    // in_sol forces column 0 even when the counter disagrees (re-alignment).
    cur_col  = in_sol_i ? '0 : col_q;
    win_d    = win_q;
    col_d    = col_q;
    cen_d    = cen_q;
    border_d = border_q;
    primed_d = primed_q;
    valid_d  = 1'b0;
    if (in_valid_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = row0_i;
      win_d[1][2] = row1_i;
      win_d[2][2] = row2_i;
      col_d       = (cur_col == LAST_COL) ? '0 : cur_col + CW'(1);
      cen_d       = (cur_col == '0) ? LAST_COL : cur_col - CW'(1);
      border_d    = (cur_col <= CW'(1));
      // The very first accept only fills the right column: nothing to emit.
      valid_d     = primed_q;
      primed_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q    <= '0;
      col_q    <= '0;
      cen_q    <= '0;
      border_q <= 1'b0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      win_q    <= win_d;
      col_q    <= col_d;
      cen_q    <= cen_d;
      border_q <= border_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    win_o = win_q;
`ifdef SOBEL_BORDER_REPLICATE_EN
    // Row ends: the left column belongs to the previous row (centre 0) or the
    // right column to the next row (centre IMG_W-1); mirror the centre instead.
    for (int r = 0; r < 3; r++) begin
      if (cen_q == '0)      win_o[r][0] = win_q[r][1];
      if (cen_q == LAST_COL) win_o[r][2] = win_q[r][1];
    end
`endif
  end

  assign win_valid_o = valid_q;
  assign cen_col_o   = cen_q;
  assign border_o    = border_q;

endmodule

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel edge magnitude, one triple per beat.
// Optional feature macro: SOBEL_BORDER_REPLICATE_EN (replicate border columns
// instead of forcing border outputs to zero).
// Handshake: no backpressure. A beat is accepted on every rising edge with
// in_valid=1; out_valid=1 marks a cycle whose out_pix/out_col/out_border
// belong to one window, two clocks after the accept edge that completed it.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   in_valid, in_sol, mode           beat qualifier, column-0 marker, result select
//   row0_pixel, row1_pixel, row2_pixel  vertical triple of the current column
//   out_pix, out_valid, out_col, out_border  registered result and tags
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter  int PIX_W     = 12,
  parameter  int OUT_W     = 12,
  parameter  int IMG_W     = 640,
  parameter  int OUT_SHIFT = 0,
  localparam int CW        = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sol,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] row0_pixel,
  input  logic [PIX_W-1:0] row1_pixel,
  input  logic [PIX_W-1:0] row2_pixel,
  output logic [OUT_W-1:0] out_pix,
  output logic             out_valid,
  output logic [CW-1:0]    out_col,
  output logic             out_border
);

  localparam int SW = sum_width(PIX_W);
  localparam int TW = tot_width(PIX_W);

  logic [2:0][2:0][PIX_W-1:0] win;
  logic                       win_valid;
  logic [CW-1:0]              cen_col;
  logic                       border0;

  sobel_window3x3 #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_win (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_sol_i    (in_sol),
    .row0_i      (row0_pixel),
    .row1_i      (row1_pixel),
    .row2_i      (row2_pixel),
    .win_o       (win),
    .win_valid_o (win_valid),
    .cen_col_o   (cen_col),
    .border_o    (border0)
  );

  // Mode rides alongside the window so it applies to the beat it came with.
  mode_e mode0_q;

  // Stage 1: gradients from the effective window.
  logic [SW-1:0] cs_l, cs_r, rs_t, rs_b;
  logic [SW-1:0] agx_d, agy_d, agx_q, agy_q;
  mode_e         mode1_q;
  logic [CW-1:0] col1_q;
  logic          border1_q, v1_q;

  always_comb begin
    cs_l  = SW'(win[0][0]) + (SW'(win[1][0]) << 1) + SW'(win[2][0]);
    cs_r  = SW'(win[0][2]) + (SW'(win[1][2]) << 1) + SW'(win[2][2]);
    rs_t  = SW'(win[0][0]) + (SW'(win[0][1]) << 1) + SW'(win[0][2]);
    rs_b  = SW'(win[2][0]) + (SW'(win[2][1]) << 1) + SW'(win[2][2]);
    agx_d = (cs_r >= cs_l) ? cs_r - cs_l : cs_l - cs_r;
    agy_d = (rs_b >= rs_t) ? rs_b - rs_t : rs_t - rs_b;
  end

  // Stage 2: mode select, scale, saturate.
  logic [TW-1:0]    res, shifted;
  logic [OUT_W-1:0] pix_d;

  always_comb begin
    case (mode1_q)
      MODE_GX:  res = TW'(agx_q);
      MODE_GY:  res = TW'(agy_q);
      MODE_SUM: res = TW'(agx_q) + TW'(agy_q);
      default:  res = (agx_q >= agy_q) ? TW'(agx_q) : TW'(agy_q);
    endcase
    shifted = res >> OUT_SHIFT;
    pix_d   = OUT_W'(sat_u32(32'(shifted), OUT_W));
`ifndef SOBEL_BORDER_REPLICATE_EN
    if (border1_q) pix_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode0_q    <= MODE_GX;
      agx_q      <= '0;
      agy_q      <= '0;
      mode1_q    <= MODE_GX;
      col1_q     <= '0;
      border1_q  <= 1'b0;
      v1_q       <= 1'b0;
      out_pix    <= '0;
      out_col    <= '0;
      out_border <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (in_valid) mode0_q <= mode_e'(mode);
      v1_q <= win_valid;
      if (win_valid) begin
        agx_q     <= agx_d;
        agy_q     <= agy_d;
        mode1_q   <= mode0_q;
        col1_q    <= cen_col;
        border1_q <= border0;
      end
      out_valid <= v1_q;
      if (v1_q) begin
        out_pix    <= pix_d;
        out_col    <= col1_q;
        out_border <= border1_q;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: directed vector table, randomized stream with gaps and
// per-beat mode changes against a reference model, and a mid-stream reset.
module tb_sobel_edge_stream;

  localparam int PIX_W     = 12;
  localparam int OUT_W     = 12;
  localparam int IMG_W     = 8;
  localparam int OUT_SHIFT = 0;
  localparam int CW        = $clog2(IMG_W);
  localparam int MAXV      = (1 << OUT_W) - 1;
  localparam int EW        = OUT_W + CW + 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sol = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [PIX_W-1:0] row0_pixel = '0;
  logic [PIX_W-1:0] row1_pixel = '0;
  logic [PIX_W-1:0] row2_pixel = '0;
  logic [OUT_W-1:0] out_pix;
  logic             out_valid;
  logic [CW-1:0]    out_col;
  logic             out_border;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_edge_stream #(
    .PIX_W(PIX_W), .OUT_W(OUT_W), .IMG_W(IMG_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sol     (in_sol),
    .mode       (mode),
    .row0_pixel (row0_pixel),
    .row1_pixel (row1_pixel),
    .row2_pixel (row2_pixel),
    .out_pix    (out_pix),
    .out_valid  (out_valid),
    .out_col    (out_col),
    .out_border (out_border)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  logic          mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs are set just after edge cyc; accept is at edge cyc+1 and the
  // result is visible after edge cyc+3.
  task automatic push_exp(input int pix, input int col, input logic bord);
    exp_q.push_back({OUT_W'(pix), CW'(col), bord});
    due_q.push_back(cyc + 3);
  endtask

  always @(negedge clk) begin : mon
    logic          exp_now;
    logic [EW-1:0] e;
    if (rst && mon_en) begin
      exp_now = 1'b0;
      if (due_q.size() > 0) exp_now = (due_q[0] == cyc);
      chk("out_valid", int'(out_valid), int'(exp_now));
      if (exp_now) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        if (out_valid) begin
          chk("out_pix",    int'(out_pix),    int'(e[EW-1 -: OUT_W]));
          chk("out_col",    int'(out_col),    int'(e[CW:1]));
          chk("out_border", int'(out_border), int'(e[0]));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Remembers the last two accepted columns; a new beat completes the window
  // (left = two beats ago, centre = previous beat, right = this beat).
  int m_col;
  int m_primed;
  int m_l[3];
  int m_c[3];

  task automatic model_reset();
    m_col = 0; m_primed = 0;
    m_l = '{0, 0, 0};
    m_c = '{0, 0, 0};
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_accept(input logic sol, input int md, input int p0, input int p1,
                              input int p2, output logic has, output int pix,
                              output int col, output logic bord);
    int c, gx, gy, res;
    int L[3], C[3], R[3];
    c    = sol ? 0 : m_col;
    has  = (m_primed != 0);
    col  = (c == 0) ? IMG_W - 1 : c - 1;
    bord = (c <= 1);
    L = m_l; C = m_c; R = '{p0, p1, p2};
`ifdef SOBEL_BORDER_REPLICATE_EN
    if (c == 1) L = C;
    if (c == 0) R = C;
`endif
    gx = iabs((R[0] + 2 * R[1] + R[2]) - (L[0] + 2 * L[1] + L[2]));
    gy = iabs((L[2] + 2 * C[2] + R[2]) - (L[0] + 2 * C[0] + R[0]));
    case (md)
      0:       res = gx;
      1:       res = gy;
      2:       res = gx + gy;
      default: res = (gx > gy) ? gx : gy;
    endcase
    res = res >> OUT_SHIFT;
    if (res > MAXV) res = MAXV;
`ifndef SOBEL_BORDER_REPLICATE_EN
    if (bord) res = 0;
`endif
    pix = res;
    m_l = m_c;
    m_c = '{p0, p1, p2};
    m_col = (c == IMG_W - 1) ? 0 : c + 1;
    m_primed = 1;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic sol, input int md, input int p0, input int p1,
                            input int p2, output logic has, output int pix,
                            output int col, output logic bord);
    in_valid   = 1'b1;
    in_sol     = sol;
    mode       = 2'(md);
    row0_pixel = PIX_W'(p0);
    row1_pixel = PIX_W'(p1);
    row2_pixel = PIX_W'(p2);
    model_accept(sol, md, p0, p1, p2, has, pix, col, bord);
  endtask

  // Idle beats carry junk that must be ignored.
  task automatic drive_idle();
    in_valid   = 1'b0;
    in_sol     = 1'($urandom_range(0, 1));
    mode       = 2'($urandom_range(0, 3));
    row0_pixel = PIX_W'($urandom_range(0, 4095));
    row1_pixel = PIX_W'($urandom_range(0, 4095));
    row2_pixel = PIX_W'($urandom_range(0, 4095));
  endtask

  task automatic do_reset();
    drive_idle();
    in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    model_reset();
    step();
    step();
    @(posedge clk);
    #3 rst = 1'b1;
    step();
  endtask

  function automatic int rpix();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 4095;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic sol;
    int   md;
    int   p0, p1, p2;
    logic has;
    int   col;
    logic bord;
    int   nm;   // expected pixel with border zeroing
    int   rep;  // expected pixel with border replication
  } vec_t;

  vec_t tab[25];

  initial begin
    logic has, bord;
    int   pix, col, texp, gap, md;
    logic sol;

    // Row A: vertical step 0 -> 100 at column 4, mode |Gx|.
    tab[0]  = '{1'b1, 0,   0,   0,    0, 1'b0, 0, 1'b0,    0,    0};
    tab[1]  = '{1'b0, 0,   0,   0,    0, 1'b1, 0, 1'b1,    0,    0};
    tab[2]  = '{1'b0, 0,   0,   0,    0, 1'b1, 1, 1'b0,    0,    0};
    tab[3]  = '{1'b0, 0,   0,   0,    0, 1'b1, 2, 1'b0,    0,    0};
    tab[4]  = '{1'b0, 0, 100, 100,  100, 1'b1, 3, 1'b0,  400,  400};
    tab[5]  = '{1'b0, 0, 100, 100,  100, 1'b1, 4, 1'b0,  400,  400};
    tab[6]  = '{1'b0, 0, 100, 100,  100, 1'b1, 5, 1'b0,    0,    0};
    tab[7]  = '{1'b0, 0, 100, 100,  100, 1'b1, 6, 1'b0,    0,    0};
    // Row B: horizontal step (bottom row 1000), mixed modes.
    tab[8]  = '{1'b1, 1,   0,   0, 1000, 1'b1, 7, 1'b1,    0,    0};
    tab[9]  = '{1'b0, 1,   0,   0, 1000, 1'b1, 0, 1'b1,    0, 4000};
    tab[10] = '{1'b0, 1,   0,   0, 1000, 1'b1, 1, 1'b0, 4000, 4000};
    tab[11] = '{1'b0, 0,   0,   0, 1000, 1'b1, 2, 1'b0,    0,    0};
    tab[12] = '{1'b0, 1,   0,   0, 1000, 1'b1, 3, 1'b0, 4000, 4000};
    tab[13] = '{1'b0, 2,   0,   0, 1000, 1'b1, 4, 1'b0, 4000, 4000};
    tab[14] = '{1'b0, 3,   0,   0, 1000, 1'b1, 5, 1'b0, 4000, 4000};
    tab[15] = '{1'b0, 1,   0,   0, 1000, 1'b1, 6, 1'b0, 4000, 4000};
    // Row C: bottom row 4095 -> raw 16380 saturates to 4095.
    tab[16] = '{1'b1, 2,   0,   0, 4095, 1'b1, 7, 1'b1,    0, 4000};
    tab[17] = '{1'b0, 2,   0,   0, 4095, 1'b1, 0, 1'b1,    0, 4095};
    tab[18] = '{1'b0, 2,   0,   0, 4095, 1'b1, 1, 1'b0, 4095, 4095};
    tab[19] = '{1'b0, 1,   0,   0, 4095, 1'b1, 2, 1'b0, 4095, 4095};
    tab[20] = '{1'b0, 0,   0,   0, 4095, 1'b1, 3, 1'b0,    0,    0};
    tab[21] = '{1'b0, 3,   0,   0, 4095, 1'b1, 4, 1'b0, 4095, 4095};
    // in_sol at column 6 re-aligns the counter to column 0.
    tab[22] = '{1'b1, 0,   0,   0,    0, 1'b1, 7, 1'b1,    0,    0};
    tab[23] = '{1'b0, 0,   0,   0,    0, 1'b1, 0, 1'b1,    0,    0};
    tab[24] = '{1'b0, 0,   0,   0,    0, 1'b1, 1, 1'b0,    0,    0};

    // Reset state.
    model_reset();
    drive_idle();
    in_valid = 1'b0;
    repeat (3) step();
    chk("rst_out_valid",  int'(out_valid),  0);
    chk("rst_out_pix",    int'(out_pix),    0);
    chk("rst_out_col",    int'(out_col),    0);
    chk("rst_out_border", int'(out_border), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    step();
    mon_en = 1'b1;

    // Directed table, back to back from reset.
    for (int i = 0; i < 25; i++) begin
      drive_beat(tab[i].sol, tab[i].md, tab[i].p0, tab[i].p1, tab[i].p2, has, pix, col, bord);
`ifdef SOBEL_BORDER_REPLICATE_EN
      texp = tab[i].rep;
`else
      texp = tab[i].nm;
`endif
      if (tab[i].has) push_exp(texp, tab[i].col, tab[i].bord);
      step();
    end
    repeat (5) begin drive_idle(); step(); end

    // Random stream: gaps of 0..3 idle cycles, new mode every beat,
    // occasional out-of-place in_sol.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin drive_idle(); step(); end
      sol = (m_col == 0) || ($urandom_range(0, 15) == 0);
      md  = $urandom_range(0, 3);
      drive_beat(sol, md, rpix(), rpix(), rpix(), has, pix, col, bord);
      if (has) push_exp(pix, col, bord);
      step();
    end

    // Mid-stream reset with beats in flight.
    for (int i = 0; i < 3; i++) begin
      drive_beat(m_col == 0, $urandom_range(0, 3), rpix(), rpix(), rpix(), has, pix, col, bord);
      if (has) push_exp(pix, col, bord);
      step();
    end
    chk("pre_reset_out_valid", int'(out_valid), 1);
    drive_idle();
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid",  int'(out_valid),  0);
    chk("async_rst_out_pix",    int'(out_pix),    0);
    chk("async_rst_out_border", int'(out_border), 0);
    exp_q.delete();
    due_q.delete();
    model_reset();
    step();
    @(posedge clk);
    #3 rst = 1'b1;
    step();
    // First accept after reset: no output. Second: output 2 clocks later.
    drive_beat(1'b1, 1, 0, 0, 0, has, pix, col, bord);
    if (has) push_exp(pix, col, bord);
    step();
    drive_idle(); step();
    drive_beat(1'b0, 1, 300, 300, 800, has, pix, col, bord);
    if (has) push_exp(pix, col, bord);
    step();
    repeat (6) begin drive_idle(); step(); end

    chk("scoreboard_drained", due_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
